// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, byte out with valid/ready and error pulses.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  modport slave (input rx, ready, output data, valid, frame_err, overrun);
  modport master(output rx, ready, input data, valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 MSB-first receiver with a one-deep output register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic     CLK,
  input logic     RESET,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  localparam int         MID    = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] LAST   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] MID_M1 = 8'(MID == 0 ? 0 : MID - 1);
  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] baud_q, baud_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       good, bad;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      bit_q   <= 3'd7;
      baud_q  <= 8'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  // baud_q counts clocks since the last sample; START waits to mid-bit, DATA/STOP a full bit.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    baud_d  = baud_q + 8'd1;
    shift_d = shift_q;
    good    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = 8'd0;
        if (!bus.rx) begin
          state_d = (MID == 0) ? DATA : START;
          bit_d   = 3'd7;
        end
      end
      START: if (baud_q == MID_M1) begin
        baud_d  = 8'd0;
        state_d = bus.rx ? IDLE : DATA;
      end
      DATA: if (baud_q == LAST) begin
        baud_d         = 8'd0;
        shift_d[bit_q] = bus.rx;
        bit_d          = bit_q - 3'd1;
        if (bit_q == 3'd0) state_d = STOP;
      end
      STOP: if (baud_q == LAST) begin
        baud_d  = 8'd0;
        bit_d   = 3'd7;
        good    = bus.rx;
        bad     = !bus.rx;
        state_d = bus.rx ? IDLE : BRK;
      end
      BRK: begin
        baud_d = 8'd0;
        if (bus.rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = good | (valid_q & ~bus.ready);
    data_d  = (good & (~valid_q | bus.ready)) ? shift_q : data_q;
    ovr_d   = good & valid_q & ~bus.ready;
    ferr_d  = bad;
  end
  always_comb begin
    bus.data      = data_q;
    bus.valid     = valid_q;
    bus.frame_err = ferr_q;
    bus.overrun   = ovr_q;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver matching the team's uart_tx frame format:
- 1 start bit (0), then 8 data bits MSB first, then 1 stop bit (1).
- Line idles high.

It deserialises `rx` into bytes and presents them on a one-deep valid/ready output register. It flags framing errors and overruns. Bit period is CLKS_PER_BIT clocks. The default of 1 matches uart_tx, which drives one bit per clock.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit. Legal range is 1..255.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line. Same clock domain as CLK, so there is no synchronizer.
- data  output  8  received byte. Held stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid&&ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0, byte discarded.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the output register was full.

Behaviour:
- Reset: all of the following take effect immediately on RESET high and hold while RESET is high.
  - State = IDLE; bit counter = 7; baud counter = 0.
  - data = 8'h00, valid = 0, frame_err = 0, overrun = 0.
- Reset mid-frame abandons the frame without any error pulse.
- Sample point: MID = (CLKS_PER_BIT-1)/2, using integer division. For CLKS_PER_BIT=1, MID=0 and every bit is sampled on its first clock.
- States:
  - IDLE: when rx=0 is sampled, set baud counter = 0. If MID==0, go directly to DATA with bit counter = 7 and baud counter reset. Otherwise go to START.
  - START: count to MID.
    - If rx=0 at MID: go to DATA and reload the baud counter so the next sample lands one full bit later.
    - If rx=1 at MID: false start, return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT clocks, sample rx into shift[bit counter].
    - Bit counter decrements 7→0.
    - After sampling bit 0, go to STOP.
  - STOP: sample rx one bit period after bit 0.
    - rx=1: frame good. Go to IDLE and deliver the byte (see Output register).
    - rx=0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx=1, then go to IDLE. The transition takes one cycle; a start bit needs rx=0 again after that.
- Back-to-back frames: from the STOP sample, IDLE must detect a new start bit on the very next sample. uart_tx can send a start bit in the cycle right after its stop bit.
- Latency with CLKS_PER_BIT=1:
  - Start bit is sampled at edge E0; data bits at E1..E8; stop bit at E9.
  - valid is high after E9, which is 9 edges after the start sample.
  - New data is visible in the cycle following the stop-bit cycle.
- Output register:
  - Good frame and valid=0: load data, set valid=1.
  - Good frame with valid=1 and ready=1 at the same edge: consume the old byte, load the new byte, valid stays 1, no overrun.
  - Good frame with valid=1 and ready=0: keep the old data, pulse overrun for 1 cycle, drop the new byte.
  - valid&&ready with no frame completing: valid→0. data keeps its last value.
- ready is ignored while valid=0.
- frame_err and overrun never assert in the same cycle.

Test Plan:
1. Default parameter, ready=1. Drive rx = 1,0,1,0,1,0,0,1,0,1,1 (idle, start, 0xA5 MSB first, stop) → valid=1 for exactly 1 cycle, in the cycle after the stop bit, with data=8'hA5. No flags.
2. Back-to-back 0x3C then 0xFF with no idle gap between the stop bit and the next start bit, ready=1 → two valid pulses 10 cycles apart, carrying 8'h3C then 8'hFF.
3. Frame 0x81 with the stop bit driven 0, then rx held 0 for 3 cycles, then 1, then a good 0x55 frame → frame_err pulses once and valid stays 0 for the bad frame. Next, valid=1 with data=8'h55.
4. ready=0. Send 0x12, then 0x34 → valid=1 with data=8'h12 throughout, and overrun pulses once at the 0x34 stop bit. Then ready=1 for 1 cycle → valid=0.
5. CLKS_PER_BIT=4. Drive a 1-clock rx=0 glitch, then a full 0xC3 frame at 4 clocks/bit → glitch ignored (no flags), then data=8'hC3 with valid=1.
6. Assert RESET asynchronously (mid-cycle) during data bit 4 of a frame → valid/flags low immediately. After release, a fresh 0x7E frame is received correctly.
